// File: rtl/alarm_scheduler.sv
// Alarm clock peripheral on an Avalon-MM slave: time-of-day counter, alarm compare,
// ring/snooze sequencing with auto-stop, and a pending interrupt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | alarm disabled (arm_en=0), counters held at zero
// ARMED   | waiting for a tick-driven time update to hit the alarm time
// RINGING | buzzer on, ring_cnt counts seconds down to auto-stop
// SNOOZE  | buzzer off, snooze_cnt counts seconds down to the next ring
module alarm_scheduler #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        alarm_out
);

    localparam int SNOOZE_SECS = SNOOZE_MINS * 60;
    localparam int RING_W      = (RING_SECS < 2) ? 1 : $clog2(RING_SECS + 1);
    localparam int SNZ_W_RAW   = $clog2(SNOOZE_SECS + 1);
    localparam int SNZ_W       = (SNZ_W_RAW < 10) ? 10 : SNZ_W_RAW;
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
    localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [5:0] sec_q, min_q, alm_min;
    logic [4:0] hour_q, alm_hour;
    logic [5:0] sec_nx, min_nx;
    logic [4:0] hour_nx;
    logic       arm_en, irq_en, pending;
    logic [RING_W-1:0] ring_cnt, ring_nx;
    logic [SNZ_W-1:0]  snooze_cnt, snz_nx;

    logic        wr_en, time_wr, min_ok, hour_ok;
    logic        cmd_dismiss, cmd_snooze, status_wr;
    logic        tick_adv, match, pend_set;
    logic [15:0] rd_mux;

    assign wr_en       = chipselect & ~write_n;
    assign time_wr     = wr_en & (address <= 3'd2);
    assign min_ok      = (writedata <= 16'd59);
    assign hour_ok     = (writedata <= 16'd23);
    assign status_wr   = wr_en & (address == 3'd6);
    assign cmd_dismiss = wr_en & (address == 3'd7) & writedata[1];
    assign cmd_snooze  = wr_en & (address == 3'd7) & writedata[0] & ~writedata[1];

    // A time write in the same cycle as a tick wins and the tick is dropped for all fields.
    always_comb begin
        sec_nx   = sec_q;
        min_nx   = min_q;
        hour_nx  = hour_q;
        tick_adv = 1'b0;
        if (time_wr) begin
            if (address == 3'd0 && min_ok) begin
                sec_nx = writedata[5:0];
            end else if (address == 3'd1 && min_ok) begin
                min_nx = writedata[5:0];
            end else if (address == 3'd2 && hour_ok) begin
                hour_nx = writedata[4:0];
            end
        end else if (tick) begin
            tick_adv = 1'b1;
            if (sec_q == 6'd59) begin
                sec_nx = 6'd0;
                if (min_q == 6'd59) begin
                    min_nx  = 6'd0;
                    hour_nx = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_nx = min_q + 6'd1;
                end
            end else begin
                sec_nx = sec_q + 6'd1;
            end
        end
    end

    assign match = tick_adv & (sec_nx == 6'd0) & (min_nx == alm_min) & (hour_nx == alm_hour);

    always_comb begin
        state_nx = state;
        ring_nx  = ring_cnt;
        snz_nx   = snooze_cnt;
        pend_set = 1'b0;
        if (!arm_en) begin
            state_nx = IDLE;
            ring_nx  = '0;
            snz_nx   = '0;
        end else begin
            case (state)
                IDLE: state_nx = ARMED;
                ARMED: begin
                    if (match) begin
                        state_nx = RINGING;
                        ring_nx  = RING_LOAD;
                        pend_set = 1'b1;
                    end
                end
                RINGING: begin
                    if (cmd_dismiss) begin
                        state_nx = ARMED;
                    end else if (cmd_snooze) begin
                        state_nx = SNOOZE;
                        snz_nx   = SNZ_LOAD;
                    end else if (tick) begin
                        if (ring_cnt <= RING_ONE) begin
                            state_nx = ARMED;
                            ring_nx  = '0;
                        end else begin
                            ring_nx = ring_cnt - RING_ONE;
                        end
                    end
                end
                SNOOZE: begin
                    if (cmd_dismiss) begin
                        state_nx = ARMED;
                    end else if (tick) begin
                        if (snooze_cnt <= SNZ_ONE) begin
                            state_nx = RINGING;
                            snz_nx   = '0;
                            ring_nx  = RING_LOAD;
                            pend_set = 1'b1;
                        end else begin
                            snz_nx = snooze_cnt - SNZ_ONE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            alarm_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            ring_cnt   <= ring_nx;
            snooze_cnt <= snz_nx;
            alarm_out  <= (state_nx == RINGING);
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            3'd0: rd_mux = {10'd0, sec_q};
            3'd1: rd_mux = {10'd0, min_q};
            3'd2: rd_mux = {11'd0, hour_q};
            3'd3: rd_mux = {10'd0, alm_min};
            3'd4: rd_mux = {11'd0, alm_hour};
            3'd5: rd_mux = {14'd0, irq_en, arm_en};
            3'd6: rd_mux = {13'd0, pending, state == SNOOZE, state == RINGING};
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            alm_min  <= '0;
            alm_hour <= '0;
            arm_en   <= 1'b0;
            irq_en   <= 1'b0;
            pending  <= 1'b0;
            readdata <= '0;
        end else begin
            sec_q  <= sec_nx;
            min_q  <= min_nx;
            hour_q <= hour_nx;
            if (wr_en && address == 3'd3 && min_ok) begin
                alm_min <= writedata[5:0];
            end
            if (wr_en && address == 3'd4 && hour_ok) begin
                alm_hour <= writedata[4:0];
            end
            if (wr_en && address == 3'd5) begin
                arm_en <= writedata[0];
                irq_en <= writedata[1];
            end
            // A new ring in the same cycle as a STATUS write keeps pending set.
            pending  <= pend_set | (pending & ~status_wr);
            readdata <= rd_mux;
        end
    end

    assign irq = pending & irq_en;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: register table, directed ring/snooze sequences,
// then random traffic against a seconds-of-day reference model.
module tb_alarm_scheduler;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_MINS = 5;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

    logic        clk = 1'b0;
    logic        reset, tick, chipselect, write_n;
    logic [2:0]  address;
    logic [15:0] writedata, readdata;
    logic        irq, alarm_out;

    int n_total = 0;
    int n_pass  = 0;

    alarm_scheduler #(.RING_SECS(RING_SECS), .SNOOZE_MINS(SNOOZE_MINS)) dut (
        .clk(clk), .reset(reset), .tick(tick), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .alarm_out(alarm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, tk, cs, wn;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        logic        exp_irq, exp_alarm;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, tk, cs, wn, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_irq, exp_alarm);
        vec_t v;
        v.r = r; v.tk = tk; v.cs = cs; v.wn = wn; v.a = a; v.d = d;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.exp_alarm = exp_alarm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic step(input logic r, tk, cs, wn, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        reset = r; tick = tk; chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b1, 1'b1, a, 16'd0);
    endtask

    task automatic tk1();
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0);
    endtask

    // Reference model: time as seconds of the day, alarm as hour/minute, mode plus seconds left.
    int          m_tod, m_alm_m, m_alm_h, m_mode, m_ring, m_snz;
    bit          m_arm, m_irqen, m_pend, m_irq, m_alarm;
    logic [15:0] m_rd;

    task automatic model_step(input logic r, tk, we, input logic [2:0] a, input logic [15:0] d);
        int sec, mn, hr, ntod;
        bit match, dis, snz, setp;
        sec = m_tod % 60; mn = (m_tod / 60) % 60; hr = m_tod / 3600;
        case (a)
            3'd0: m_rd = 16'(sec);
            3'd1: m_rd = 16'(mn);
            3'd2: m_rd = 16'(hr);
            3'd3: m_rd = 16'(m_alm_m);
            3'd4: m_rd = 16'(m_alm_h);
            3'd5: m_rd = {14'd0, m_irqen, m_arm};
            3'd6: m_rd = {13'd0, m_pend, m_mode == M_SNOOZE, m_mode == M_RING};
            default: m_rd = 16'd0;
        endcase
        if (r) begin
            m_tod = 0; m_alm_m = 0; m_alm_h = 0; m_mode = M_IDLE; m_ring = 0; m_snz = 0;
            m_arm = 0; m_irqen = 0; m_pend = 0; m_rd = 16'd0;
        end else begin
            ntod = m_tod; match = 0; setp = 0;
            if (we && a <= 3'd2) begin
                if (a == 3'd0 && d <= 59) ntod = hr * 3600 + mn * 60 + int'(d);
                if (a == 3'd1 && d <= 59) ntod = hr * 3600 + int'(d) * 60 + sec;
                if (a == 3'd2 && d <= 23) ntod = int'(d) * 3600 + mn * 60 + sec;
            end else if (tk) begin
                ntod  = (m_tod + 1) % 86400;
                match = (ntod % 60 == 0) && (ntod / 60 == m_alm_h * 60 + m_alm_m);
            end
            dis = we && a == 3'd7 && d[1];
            snz = we && a == 3'd7 && d[0] && !d[1];
            if (!m_arm) begin
                m_mode = M_IDLE; m_ring = 0; m_snz = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                if (match) begin m_mode = M_RING; m_ring = RING_SECS; setp = 1; end
            end else if (m_mode == M_RING) begin
                if (dis) m_mode = M_ARMED;
                else if (snz) begin m_mode = M_SNOOZE; m_snz = SNOOZE_MINS * 60; end
                else if (tk) begin
                    m_ring--;
                    if (m_ring <= 0) begin m_mode = M_ARMED; m_ring = 0; end
                end
            end else begin
                if (dis) m_mode = M_ARMED;
                else if (tk) begin
                    m_snz--;
                    if (m_snz <= 0) begin m_mode = M_RING; m_snz = 0; m_ring = RING_SECS; setp = 1; end
                end
            end
            if (we && a == 3'd3 && d <= 59) m_alm_m = int'(d);
            if (we && a == 3'd4 && d <= 23) m_alm_h = int'(d);
            if (we && a == 3'd5) begin m_arm = d[0]; m_irqen = d[1]; end
            m_pend = setp || (m_pend && !(we && a == 3'd6));
            m_tod  = ntod;
        end
        m_irq   = m_pend && m_irqen;
        m_alarm = (m_mode == M_RING);
    endtask

    task automatic mstep(input logic r, tk, cs, wn, input logic [2:0] a, input logic [15:0] d);
        model_step(r, tk, cs & ~wn, a, d);
        step(r, tk, cs, wn, a, d);
        chk("rand_readdata", readdata, m_rd);
        chk("rand_irq", {15'd0, irq}, {15'd0, m_irq});
        chk("rand_alarm_out", {15'd0, alarm_out}, {15'd0, m_alarm});
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 16'd0;

        add(1, 0, 0, 1, 3'd0, 16'd0,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd2, 16'd23,     16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd1, 16'd59,     16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd0, 16'd59,     16'd0,  0, 0);
        add(0, 1, 0, 1, 3'd2, 16'd0,      16'd23, 0, 0);
        add(0, 0, 0, 1, 3'd2, 16'd0,      16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd1, 16'd0,      16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd0, 16'd0,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd1, 16'd5,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd1, 16'd60,     16'd5,  0, 0);
        add(0, 0, 0, 1, 3'd1, 16'd0,      16'd5,  0, 0);
        add(0, 1, 1, 0, 3'd0, 16'd10,     16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd0, 16'd0,      16'd10, 0, 0);
        add(0, 0, 1, 0, 3'd2, 16'd24,     16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd2, 16'd0,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd4, 16'd23,     16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd4, 16'd0,      16'd23, 0, 0);
        add(0, 0, 1, 0, 3'd3, 16'd59,     16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd3, 16'd0,      16'd59, 0, 0);
        add(0, 0, 1, 0, 3'd5, 16'hFFFF,   16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd5, 16'd0,      16'd3,  0, 0);
        add(0, 0, 0, 1, 3'd7, 16'd0,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd7, 16'd3,      16'd0,  0, 0);
        add(0, 0, 0, 1, 3'd6, 16'd0,      16'd0,  0, 0);
        add(0, 0, 1, 0, 3'd0, 16'h013B,   16'd10, 0, 0);
        add(0, 0, 0, 1, 3'd0, 16'd0,      16'd10, 0, 0);
        add(0, 0, 0, 0, 3'd0, 16'd5,      16'd10, 0, 0);
        add(0, 0, 0, 1, 3'd0, 16'd0,      16'd10, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].tk, vecs[i].cs, vecs[i].wn, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
            chk($sformatf("vec%0d_alarm", i), {15'd0, alarm_out}, {15'd0, vecs[i].exp_alarm});
        end

        // Ring at 07:30 and auto-stop after RING_SECS ticks
        step(1, 0, 0, 1, 3'd0, 16'd0);
        wr(3'd4, 16'd7); wr(3'd3, 16'd30); wr(3'd2, 16'd7); wr(3'd1, 16'd29); wr(3'd0, 16'd59);
        wr(3'd5, 16'd3); rd(3'd0);
        tk1();
        chk("ring_start_alarm", {15'd0, alarm_out}, 16'd1);
        chk("ring_start_irq", {15'd0, irq}, 16'd1);
        for (int i = 0; i < RING_SECS - 1; i++) tk1();
        chk("ring_before_stop", {15'd0, alarm_out}, 16'd1);
        tk1();
        chk("ring_auto_stop", {15'd0, alarm_out}, 16'd0);
        rd(3'd6);
        chk("status_after_stop", readdata, 16'd4);
        wr(3'd6, 16'd0);
        chk("irq_cleared", {15'd0, irq}, 16'd0);

        // Snooze, re-ring with simultaneous STATUS write, dismiss
        wr(3'd1, 16'd29); wr(3'd0, 16'd59); tk1();
        chk("ring2_alarm", {15'd0, alarm_out}, 16'd1);
        wr(3'd6, 16'd0);
        wr(3'd7, 16'd1);
        chk("snooze_alarm_off", {15'd0, alarm_out}, 16'd0);
        rd(3'd6);
        chk("snooze_status", readdata, 16'd2);
        for (int i = 0; i < SNOOZE_MINS * 60 - 1; i++) tk1();
        chk("snooze_before_end", {15'd0, alarm_out}, 16'd0);
        step(0, 1, 1, 0, 3'd6, 16'd0);
        chk("snooze_rering_alarm", {15'd0, alarm_out}, 16'd1);
        chk("pending_set_wins", {15'd0, irq}, 16'd1);
        rd(3'd6);
        chk("rering_status", readdata, 16'd5);
        wr(3'd7, 16'd2);
        chk("dismiss_alarm", {15'd0, alarm_out}, 16'd0);
        rd(3'd6);
        chk("dismiss_status", readdata, 16'd4);
        wr(3'd6, 16'd0);

        // Both command bits at once: dismiss wins
        wr(3'd1, 16'd29); wr(3'd0, 16'd59); tk1();
        wr(3'd7, 16'd3);
        chk("both_cmd_alarm", {15'd0, alarm_out}, 16'd0);
        rd(3'd6);
        chk("both_cmd_status", readdata, 16'd4);
        wr(3'd6, 16'd0);

        // Direct write of the alarm time must not ring; clearing arm_en stops a ring
        wr(3'd2, 16'd7); wr(3'd1, 16'd30); wr(3'd0, 16'd0); rd(3'd6);
        chk("write_no_ring_alarm", {15'd0, alarm_out}, 16'd0);
        chk("write_no_ring_status", readdata, 16'd0);
        wr(3'd1, 16'd29); wr(3'd0, 16'd59); tk1();
        chk("ring3_alarm", {15'd0, alarm_out}, 16'd1);
        wr(3'd5, 16'd2);
        rd(3'd6);
        chk("disarm_alarm", {15'd0, alarm_out}, 16'd0);
        wr(3'd7, 16'd1);
        rd(3'd6);
        chk("idle_status", readdata, 16'd4);

        // Reset mid-snooze with a concurrent write and tick
        wr(3'd6, 16'd0); wr(3'd5, 16'd3); rd(3'd0);
        wr(3'd1, 16'd29); wr(3'd0, 16'd59); tk1();
        wr(3'd7, 16'd1);
        for (int i = 0; i < 5; i++) tk1();
        chk("pre_reset_irq", {15'd0, irq}, 16'd1);
        step(1, 1, 1, 0, 3'd0, 16'd30);
        chk("reset_readdata", readdata, 16'd0);
        chk("reset_irq", {15'd0, irq}, 16'd0);
        chk("reset_alarm", {15'd0, alarm_out}, 16'd0);
        for (int a = 0; a < 7; a++) begin
            rd(3'(a));
            chk($sformatf("reset_reg%0d", a), readdata, 16'd0);
        end

        // Random traffic against the reference model
        mstep(1, 0, 0, 1, 3'd0, 16'd0);
        mstep(0, 0, 1, 0, 3'd4, 16'd7);
        mstep(0, 0, 1, 0, 3'd3, 16'd30);
        mstep(0, 0, 1, 0, 3'd2, 16'd7);
        mstep(0, 0, 1, 0, 3'd1, 16'd29);
        mstep(0, 0, 1, 0, 3'd0, 16'd30);
        mstep(0, 0, 1, 0, 3'd5, 16'd3);
        for (int i = 0; i < 4000; i++) begin
            logic r, tk, cs, wn;
            logic [2:0] a;
            logic [15:0] d;
            int sel;
            r  = ($urandom_range(0, 999) == 0);
            tk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                cs = 1'b1; wn = 1'b0;
                sel = int'($urandom_range(0, 31));
                if (sel == 0) begin a = 3'd0; d = 16'($urandom_range(0, 63)); end
                else if (sel == 1) begin a = 3'd1; d = ($urandom_range(0, 3) == 0) ? 16'd70 : 16'd29; end
                else if (sel == 2) begin a = 3'd2; d = ($urandom_range(0, 3) == 0) ? 16'd25 : 16'd7; end
                else if (sel == 3) begin a = 3'd3; d = 16'($urandom_range(29, 30)); end
                else if (sel == 4) begin a = 3'd4; d = 16'd7; end
                else if (sel <= 12) begin
                    a = 3'd5;
                    d = {14'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0)};
                end
                else if (sel <= 20) begin a = 3'd6; d = 16'($urandom); end
                else begin a = 3'd7; d = 16'($urandom_range(0, 3)); end
            end else begin
                cs = 1'($urandom_range(0, 1));
                wn = cs ? 1'b1 : 1'($urandom_range(0, 1));
                a  = 3'($urandom_range(0, 7));
                d  = 16'($urandom);
            end
            mstep(r, tk, cs, wn, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
